fb_scanout_dbuf: RTL



---
 rtl/fb_scanout_dbuf.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fb_scanout_dbuf.sv
// Double-buffered framebuffer scanout: integer upscale, BRAM read issue, colour
// expansion with sync re-alignment, and vsync-gated bank swap handshake.
module fb_scanout_dbuf #(
  parameter int          FB_W       = 320,
  parameter int          FB_H       = 240,
  parameter int          SCALE_LOG2 = 1,
  parameter int          PIX_BITS   = 8,
  parameter int          RD_LAT     = 2,
  parameter int          ADDR_W     = 17,
  parameter logic [11:0] BORDER     = 12'h000
) (
  input  logic                pixel_clk,
  input  logic                arstn,
  input  logic [9:0]          drawX,
  input  logic [9:0]          drawY,
  input  logic                vde,
  input  logic                hsync,
  input  logic                vsync,
  input  logic                swap_req,
  output logic                swap_ack,
  output logic                back_sel,
  output logic [15:0]         frame_cnt,
  output logic                rd_en,
  output logic                rd_bank,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [PIX_BITS-1:0] rd_data,
  output logic [3:0]          red,
  output logic [3:0]          green,
  output logic [3:0]          blue,
  output logic                vde_o,
  output logic                hsync_o,
  output logic                vsync_o
);

  localparam int SYNC_LAT = RD_LAT + 2;

  typedef enum logic {IDLE, PENDING} swap_state_t;

  swap_state_t      state_reg;
  logic             front_sel;
  logic             vs_q;
  logic             vs_edge;

  logic [9:0]        fx;
  logic [9:0]        fy;
  logic              inimg;
  logic [ADDR_W-1:0] addr_next;

  logic [1:0]  tag_reg  [RD_LAT+1];
  logic [2:0]  sync_reg [SYNC_LAT];
  logic [11:0] pix_rgb;
  logic [11:0] rgb_reg;

  assign fx        = drawX >> SCALE_LOG2;
  assign fy        = drawY >> SCALE_LOG2;
  assign inimg     = vde && (32'(fx) < FB_W) && (32'(fy) < FB_H);
  assign addr_next = ADDR_W'(fy) * ADDR_W'(FB_W) + ADDR_W'(fx);

  // Stage A: rd_bank samples front_sel here, so reads already in flight
  // finish on the bank they were issued against.
  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      rd_bank <= 1'b0;
    end else begin
      rd_en   <= inimg;
      rd_bank <= front_sel;
      if (inimg) rd_addr <= addr_next;
    end
  end

  // tag_reg[0] is the stage-A tag; tag_reg[RD_LAT] lines up with rd_data.
  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      for (int i = 0; i <= RD_LAT; i++) tag_reg[i] <= 2'b00;
      for (int i = 0; i < SYNC_LAT; i++) sync_reg[i] <= 3'b011;
    end else begin
      tag_reg[0]  <= {vde, inimg};
      sync_reg[0] <= {vde, hsync, vsync};
      for (int i = 1; i <= RD_LAT; i++) tag_reg[i] <= tag_reg[i-1];
      for (int i = 1; i < SYNC_LAT; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end

  generate
    if (PIX_BITS == 16) begin : g_rgb565
      logic unused_lsbs;
      assign unused_lsbs = ^{rd_data[11], rd_data[5], rd_data[0]};
      assign pix_rgb = {rd_data[15:12], rd_data[10:7], rd_data[4:1]};
    end else begin : g_rgb332
      assign pix_rgb = {rd_data[7:5], rd_data[7], rd_data[4:2], rd_data[4],
                        rd_data[1:0], rd_data[1:0]};
    end
  endgenerate

  always_ff @(posedge pixel_clk) begin
    if (!arstn)                   rgb_reg <= 12'h000;
    else if (!tag_reg[RD_LAT][1]) rgb_reg <= 12'h000;
    else if (!tag_reg[RD_LAT][0]) rgb_reg <= BORDER;
    else                          rgb_reg <= pix_rgb;
  end

  assign {red, green, blue}        = rgb_reg;
  assign {vde_o, hsync_o, vsync_o} = sync_reg[SYNC_LAT-1];

  // A request seen on the edge cycle itself is honoured straight from IDLE.
  assign vs_edge = vs_q & ~vsync;

  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      state_reg <= IDLE;
      front_sel <= 1'b0;
      back_sel  <= 1'b1;
      swap_ack  <= 1'b0;
      frame_cnt <= 16'h0000;
      vs_q      <= 1'b1;
    end else begin
      vs_q     <= vsync;
      swap_ack <= 1'b0;
      if (vs_edge) frame_cnt <= frame_cnt + 16'd1;
      case (state_reg)
        IDLE: begin
          if (swap_req) begin
            if (vs_edge) begin
              front_sel <= ~front_sel;
              back_sel  <= front_sel;
              swap_ack  <= 1'b1;
            end else begin
              state_reg <= PENDING;
            end
          end
        end
        PENDING: begin
          if (vs_edge) begin
            front_sel <= ~front_sel;
            back_sel  <= front_sel;
            swap_ack  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
